// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency, single-port memory between the CPU and a DMA/loader port.
// Each grant is latched and runs for WAIT_CYC cycles, then a one-cycle ready pulse is spent in IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

    state_t     state;
    logic [3:0] count;
    logic       last_dma;
    logic       cpu_elig;
    logic       dma_elig;
    logic       grant_cpu;
    logic       grant_dma;

    // A port whose ready is high is completing this cycle and must not retrigger.
    assign cpu_elig  = cpu_req & ~cpu_ready;
    assign dma_elig  = dma_req & ~dma_ready;
    assign grant_cpu = cpu_elig & (~dma_elig | last_dma);
    assign grant_dma = dma_elig & (~cpu_elig | ~last_dma);

    assign cpu_stall = cpu_req & ~cpu_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            last_dma  <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        state     <= CPU_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        count     <= 4'd0;
                        last_dma  <= 1'b0;
                    end else if (grant_dma) begin
                        state     <= DMA_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= dma_we;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        count     <= 4'd0;
                        last_dma  <= 1'b1;
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    count <= count + 4'd1;
                    if (count == LAST_CNT) begin
                        // mem_rdata is valid on this final access cycle.
                        if (state == CPU_ACC) begin
                            cpu_ready <= 1'b1;
                            if (!mem_we) cpu_rdata <= mem_rdata;
                        end else begin
                            dma_ready <= 1'b1;
                            if (!mem_we) dma_rdata <= mem_rdata;
                        end
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        count  <= 4'd0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
